// File: rtl/fu_cdb_tx_pkg.sv
// Shared definitions for the FU-to-CDB result transmit buffer.
// The ROB tag width is common to every FU instance and the CDB arbiter.
package fu_cdb_tx_pkg;

  localparam int ROB_TAG_BITS = 5;
  localparam int XLEN_DEFAULT = 32;

  // True when n is a nonzero power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage : fu_cdb_tx_pkg

// File: rtl/fu_cdb_tx_if.sv
// FU-side and CDB-side handshake of one result transmit buffer.
// The slave view belongs to the buffer; the master view belongs to its environment.
interface fu_cdb_tx_if
  import fu_cdb_tx_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) ();

  logic                    fu_valid_in;
  logic [XLEN-1:0]         fu_value_in;
  logic [ROB_TAG_BITS-1:0] fu_rob_tag_in;
  logic                    fu_ready;
  logic                    cdb_ack;
  logic                    cdb_done;
  logic [XLEN-1:0]         cdb_v;
  logic [ROB_TAG_BITS-1:0] cdb_rob_tag;
  logic                    overflow_err;

  modport slave (
    input  fu_valid_in, fu_value_in, fu_rob_tag_in, cdb_ack,
    output fu_ready, cdb_done, cdb_v, cdb_rob_tag, overflow_err
  );

  modport master (
    output fu_valid_in, fu_value_in, fu_rob_tag_in, cdb_ack,
    input  fu_ready, cdb_done, cdb_v, cdb_rob_tag, overflow_err
  );

endinterface : fu_cdb_tx_if

// File: rtl/fu_cdb_tx.sv
// Per-FU result FIFO feeding the common data bus: the head result is offered
// on cdb_* until the arbiter acks it; fu_ready depends on registered state only.
module fu_cdb_tx
  import fu_cdb_tx_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  fu_cdb_tx_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]         value;
    logic [ROB_TAG_BITS-1:0] rob_tag;
  } fu_result_entry_t;

  fu_result_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0]        r_head;
  logic [PTR_W-1:0]        r_tail;
  logic [CNT_W-1:0]        r_count;
  logic                    r_overflow;

  logic                    w_empty;
  logic                    w_full;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  fu_result_entry_t        w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));

  // Acceptance is judged on the registered count alone, so a full buffer
  // refuses a push even when the head leaves on the same edge.
  assign w_push  = bus.fu_valid_in && !w_full;
  assign w_pop   = bus.cdb_ack && !w_empty;
  assign w_drop  = bus.fu_valid_in && w_full;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      // NOTE: the storage array is reset as well, so cdb_* never exposes
      // stale or unknown data after reset, even through a faulty read path.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= '{value: bus.fu_value_in, rob_tag: bus.fu_rob_tag_in};
          r_tail        <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign w_head           = r_mem[r_head];
  assign bus.cdb_done     = !w_empty;
  assign bus.cdb_v        = w_empty ? '0 : w_head.value;
  assign bus.cdb_rob_tag  = w_empty ? '0 : w_head.rob_tag;
  assign bus.fu_ready     = !w_full;
  assign bus.overflow_err = r_overflow;

endmodule : fu_cdb_tx

// File: tb/tb_fu_cdb_tx.sv
// Self-checking bench for fu_cdb_tx: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_fu_cdb_tx;
  import fu_cdb_tx_pkg::*;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic clock;
  logic reset;
  logic clear;

  fu_cdb_tx_if #(.XLEN(XLEN)) bus ();

  fu_cdb_tx #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [XLEN-1:0]         value;
    logic [ROB_TAG_BITS-1:0] tag;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input bit v, input int value, input int tag, input bit ack);
    bus.fu_valid_in   = v;
    bus.fu_value_in   = XLEN'(value);
    bus.fu_rob_tag_in = ROB_TAG_BITS'(tag);
    bus.cdb_ack       = ack;
  endtask

  // Reference model: on each falling edge, compare outputs to the model, then
  // apply the inputs that the coming rising edge will sample.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        check("cyc_done",  64'(bus.cdb_done),     64'(mq.size() != 0));
        check("cyc_v",     64'(bus.cdb_v),        (mq.size() != 0) ? 64'(mq[0].value) : 64'd0);
        check("cyc_tag",   64'(bus.cdb_rob_tag),  (mq.size() != 0) ? 64'(mq[0].tag)   : 64'd0);
        check("cyc_ready", 64'(bus.fu_ready),     64'(mq.size() != DEPTH));
        check("cyc_ovf",   64'(bus.overflow_err), 64'(m_ovf));
      end
      if (reset === 1'b1) begin
        mq.delete();
        m_ovf = 1'b0;
      end else begin
        bit full;
        bit do_pop;
        bit do_push;
        full    = (mq.size() == DEPTH);
        do_pop  = (bus.cdb_ack === 1'b1) && (mq.size() != 0);
        do_push = (bus.fu_valid_in === 1'b1) && !full;
        if ((bus.fu_valid_in === 1'b1) && full) m_ovf = 1'b1;
        if (clear === 1'b1) begin
          mq.delete();
        end else begin
          if (do_pop) void'(mq.pop_front());
          if (do_push) mq.push_back('{value: bus.fu_value_in, tag: bus.fu_rob_tag_in});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ROB_TAG_BITS-1:0] seen[$];

    reset = 1'b1;
    clear = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_en = 1'b1;

    // Reset state
    check("rst_done",  64'(bus.cdb_done),     64'd0);
    check("rst_v",     64'(bus.cdb_v),        64'd0);
    check("rst_tag",   64'(bus.cdb_rob_tag),  64'd0);
    check("rst_ready", 64'(bus.fu_ready),     64'd1);
    check("rst_ovf",   64'(bus.overflow_err), 64'd0);

    // Latency: push (40,4), visible after one edge; ack three cycles later
    drive(1, 40, 4, 0);
    tick();
    drive(0, 0, 0, 0);
    check("lat_done", 64'(bus.cdb_done),    64'd1);
    check("lat_v",    64'(bus.cdb_v),       64'd40);
    check("lat_tag",  64'(bus.cdb_rob_tag), 64'd4);
    tick();
    tick();
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    check("lat_pop_done", 64'(bus.cdb_done), 64'd0);

    // Full and hold
    drive(1, 10, 1, 0);
    tick();
    drive(1, 20, 2, 0);
    tick();
    drive(0, 0, 0, 0);
    check("full_ready", 64'(bus.fu_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_v",   64'(bus.cdb_v),       64'd10);
      check("hold_tag", 64'(bus.cdb_rob_tag), 64'd1);
    end
    drive(1, 99, 9, 0);
    tick();
    drive(0, 0, 0, 0);
    check("ovf_set",   64'(bus.overflow_err), 64'd1);
    check("ovf_v",     64'(bus.cdb_v),        64'd10);
    check("ovf_ready", 64'(bus.fu_ready),     64'd0);

    // Pop to count=1, then simultaneous push and pop
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    check("pp_head_v",   64'(bus.cdb_v),       64'd20);
    check("pp_head_tag", 64'(bus.cdb_rob_tag), 64'd2);
    drive(1, 30, 3, 1);
    tick();
    drive(0, 0, 0, 0);
    check("pp_v",     64'(bus.cdb_v),       64'd30);
    check("pp_tag",   64'(bus.cdb_rob_tag), 64'd3);
    check("pp_ready", 64'(bus.fu_ready),    64'd1);
    drive(0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0);
    check("pp_drained", 64'(bus.cdb_done), 64'd0);

    // Wrap: six results streamed with ack held high
    for (int i = 1; i <= 6; i++) begin
      drive(1, i * 11, i, 1);
      tick();
      if (bus.cdb_done) seen.push_back(bus.cdb_rob_tag);
    end
    drive(0, 0, 0, 1);
    for (int k = 0; k < 8 && bus.cdb_done; k++) begin
      tick();
      if (bus.cdb_done) seen.push_back(bus.cdb_rob_tag);
    end
    drive(0, 0, 0, 0);
    check("wrap_drained", 64'(bus.cdb_done), 64'd0);
    check("wrap_count",   64'(seen.size()),  64'd6);
    for (int i = 0; i < 6; i++) begin
      check("wrap_order", (i < seen.size()) ? 64'(seen[i]) : 64'hdead, 64'(i + 1));
    end

    // Clear while full, with a same-cycle push
    drive(1, 60, 6, 0);
    tick();
    drive(1, 70, 7, 0);
    tick();
    check("clr_full", 64'(bus.fu_ready), 64'd0);
    clear = 1'b1;
    drive(1, 50, 5, 0);
    tick();
    clear = 1'b0;
    drive(0, 0, 0, 0);
    check("clr_done",  64'(bus.cdb_done),     64'd0);
    check("clr_ready", 64'(bus.fu_ready),     64'd1);
    check("clr_v",     64'(bus.cdb_v),        64'd0);
    check("clr_ovf",   64'(bus.overflow_err), 64'd1);
    tick();
    check("clr_not_enq", 64'(bus.cdb_done), 64'd0);

    // Push after clear lands at slot 0 again
    drive(1, 80, 8, 0);
    tick();
    drive(0, 0, 0, 0);
    check("post_clr_v", 64'(bus.cdb_v), 64'd80);

    // Reset mid-operation discards the pending result and the sticky flag
    reset = 1'b1;
    drive(1, 90, 9, 1);
    tick();
    reset = 1'b0;
    drive(0, 0, 0, 0);
    check("mid_rst_done", 64'(bus.cdb_done),     64'd0);
    check("mid_rst_ovf",  64'(bus.overflow_err), 64'd0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_fu_cdb_tx
